// File: rtl/random_sequence_controller.sv
// random_sequence_controller
// Grows a random 2-bit symbol sequence by one entry per round, plays the whole
// sequence to the display stage, then checks the player's entries in order.
// Every output is decoded from registered state only; button and LFSR inputs
// never reach an output combinationally.

module random_sequence_controller #(
   parameter int MAX_LEN     = 16,
   parameter int SHOW_CYCLES = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int LW          = $clog2(MAX_LEN + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          rnd_get,
   input  logic [1:0]    rnd_value,
   input  logic          btn_valid,
   input  logic [1:0]    btn_value,
   output logic          show_valid,
   output logic [1:0]    show_value,
   output logic          busy,
   output logic [LW-1:0] level,
   output logic          win,
   output logic          fail
);

   localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ADD      = 3'd1;
   localparam logic [2:0] S_CAPT     = 3'd2;
   localparam logic [2:0] S_SHOW_ON  = 3'd3;
   localparam logic [2:0] S_SHOW_GAP = 3'd4;
   localparam logic [2:0] S_WAIT_IN  = 3'd5;
   localparam logic [2:0] S_WIN      = 3'd6;
   localparam logic [2:0] S_FAIL     = 3'd7;

   logic [2:0]    r_state;
   logic [LW-1:0] r_level;
   logic [IW-1:0] r_index;
   logic [TW-1:0] r_timer;
   logic [1:0]    r_mem [MAX_LEN];

   logic          w_atLast;
   logic          w_isMax;
   logic          w_showDone;
   logic          w_gapDone;
   logic [1:0]    w_memAtIdx;
   logic [IW-1:0] w_wrAddr;

   // index points at the final symbol of the current sequence
   assign w_atLast   = (LW'(r_index) == (r_level - LW'(1)));
   assign w_isMax    = (r_level == LW'(MAX_LEN));
   assign w_showDone = (r_timer == TW'(SHOW_CYCLES - 1));
   assign w_gapDone  = (r_timer == TW'(GAP_CYCLES - 1));
   assign w_memAtIdx = r_mem[r_index];
   // level is always below MAX_LEN while capturing, so it fits the address
   assign w_wrAddr   = IW'(r_level);

   assign rnd_get    = (r_state == S_ADD);
   assign show_valid = (r_state == S_SHOW_ON);
   assign show_value = (r_state == S_SHOW_ON) ? w_memAtIdx : 2'b00;
   assign busy       = (r_state != S_IDLE) && (r_state != S_WIN) && (r_state != S_FAIL);
   assign level      = r_level;
   assign win        = (r_state == S_WIN);
   assign fail       = (r_state == S_FAIL);

   // Sequence memory: one new symbol from the LFSR per round, no reset needed
   always_ff @(posedge clk) begin
      if (r_state == S_CAPT) begin
         r_mem[w_wrAddr] <= rnd_value;
      end
   end

   // Main game FSM: round growth, timed playback and entry checking
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_level <= '0;
         r_index <= '0;
         r_timer <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_WIN, S_FAIL: begin
               if (start) begin
                  r_level <= '0;
                  r_index <= '0;
                  r_state <= S_ADD;
               end
            end
            S_ADD: begin
               r_state <= S_CAPT;
            end
            S_CAPT: begin
               r_level <= r_level + LW'(1);
               r_index <= '0;
               r_timer <= '0;
               r_state <= S_SHOW_ON;
            end
            S_SHOW_ON: begin
               if (w_showDone) begin
                  r_timer <= '0;
                  r_state <= S_SHOW_GAP;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            S_SHOW_GAP: begin
               if (w_gapDone) begin
                  r_timer <= '0;
                  if (w_atLast) begin
                     r_index <= '0;
                     r_state <= S_WAIT_IN;
                  end else begin
                     r_index <= r_index + IW'(1);
                     r_state <= S_SHOW_ON;
                  end
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            S_WAIT_IN: begin
               if (btn_valid) begin
                  if (btn_value != w_memAtIdx) begin
                     r_state <= S_FAIL;
                  end else if (!w_atLast) begin
                     r_index <= r_index + IW'(1);
                  end else if (w_isMax) begin
                     r_state <= S_WIN;
                  end else begin
                     r_state <= S_ADD;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_random_sequence_controller.sv
// tb_random_sequence_controller
// Drives the sequencer with a behavioural 3-bit LFSR (seed 111, taps [2]^[0])
// and random player timing, and compares every output against a sequence
// model held as a queue of the symbols the generator has produced.

module tb_random_sequence_controller;

   localparam int MAX_LEN     = 4;
   localparam int SHOW_CYCLES = 4;
   localparam int GAP_CYCLES  = 2;
   localparam int LW          = $clog2(MAX_LEN + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          rnd_get;
   logic [1:0]    rnd_value;
   logic          btn_valid;
   logic [1:0]    btn_value;
   logic          show_valid;
   logic [1:0]    show_value;
   logic          busy;
   logic [LW-1:0] level;
   logic          win;
   logic          fail;

   logic [2:0]    lfsr;
   logic          lfsrReseed;
   logic [2:0]    modelState;
   logic [1:0]    seq [$];
   int            getCount = 0;
   int            base;
   int            checks;
   int            errors;

   random_sequence_controller #(
      .MAX_LEN     (MAX_LEN),
      .SHOW_CYCLES (SHOW_CYCLES),
      .GAP_CYCLES  (GAP_CYCLES),
      .LW          (LW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .rnd_get    (rnd_get),
      .rnd_value  (rnd_value),
      .btn_valid  (btn_valid),
      .btn_value  (btn_value),
      .show_valid (show_valid),
      .show_value (show_value),
      .busy       (busy),
      .level      (level),
      .win        (win),
      .fail       (fail)
   );

   // 10-unit clock period
   always #5 clk = ~clk;

   function automatic logic [2:0] lfsrNext(input logic [2:0] s);
      return {s[2] ^ s[0], s[2:1]};
   endfunction

   // External LFSR generator, advanced by the controller's get strobe
   always @(posedge clk) begin
      if (lfsrReseed) lfsr <= 3'b111;
      else if (rnd_get) lfsr <= lfsrNext(lfsr);
   end
   assign rnd_value = lfsr[1:0];

   // Count every get strobe the controller issues
   always @(posedge clk) begin
      if (rnd_get === 1'b1) getCount++;
   end

   // Watchdog so the run always terminates
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic stepCycle;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag, input int expGet, input int expShow, input int expBusy,
                           input int expLevel, input int expWin, input int expFail);
      checkOutput({tag, ".rnd_get"}, 32'(rnd_get), expGet);
      checkOutput({tag, ".show_valid"}, 32'(show_valid), expShow);
      checkOutput({tag, ".busy"}, 32'(busy), expBusy);
      checkOutput({tag, ".level"}, 32'(level), expLevel);
      checkOutput({tag, ".win"}, 32'(win), expWin);
      checkOutput({tag, ".fail"}, 32'(fail), expFail);
   endtask

   // Called in the ADD cycle: model the new symbol, then walk ADD and CAPT
   task automatic applyStimulus;
      modelState = lfsrNext(modelState);
      seq.push_back(modelState[1:0]);
      checkOutput("add.rnd_get", 32'(rnd_get), 1);
      checkOutput("add.busy", 32'(busy), 1);
      stepCycle;
      checkOutput("capt.rnd_get", 32'(rnd_get), 0);
      checkOutput("capt.show_valid", 32'(show_valid), 0);
      stepCycle;
   endtask

   task automatic startGame;
      start = 1'b1;
      stepCycle;
      start = 1'b0;
      seq.delete();
      checkOutput("start.level", 32'(level), 0);
      checkOutput("start.win", 32'(win), 0);
      checkOutput("start.fail", 32'(fail), 0);
      applyStimulus;
   endtask

   // Whole-sequence playback with random ignored button pulses
   task automatic playback;
      for (int i = 0; i < seq.size(); i++) begin
         for (int c = 0; c < SHOW_CYCLES; c++) begin
            checkOutput("show.valid", 32'(show_valid), 1);
            checkOutput("show.value", 32'(show_value), 32'(seq[i]));
            checkOutput("show.level", 32'(level), seq.size());
            btn_valid = ($urandom_range(0, 2) == 0);
            btn_value = 2'($urandom);
            stepCycle;
         end
         for (int c = 0; c < GAP_CYCLES; c++) begin
            checkOutput("gap.valid", 32'(show_valid), 0);
            checkOutput("gap.value", 32'(show_value), 0);
            checkOutput("gap.busy", 32'(busy), 1);
            btn_valid = ($urandom_range(0, 2) == 0);
            btn_value = 2'($urandom);
            stepCycle;
         end
      end
      btn_valid = 1'b0;
      btn_value = 2'b00;
      checkAll("wait", 0, 0, 1, seq.size(), 0, 0);
   endtask

   // Player entries with random think time; wrongAt selects a bad entry
   task automatic enterSequence(input int wrongAt, input logic [1:0] wrongVal);
      int idle;
      for (int i = 0; i < seq.size(); i++) begin
         idle = $urandom_range(0, 2);
         for (int k = 0; k < idle; k++) begin
            stepCycle;
            checkOutput("idle.busy", 32'(busy), 1);
         end
         btn_valid = 1'b1;
         btn_value = (i == wrongAt) ? wrongVal : seq[i];
         stepCycle;
         btn_valid = 1'b0;
         btn_value = 2'b00;
         if (i == wrongAt) return;
         if (i < seq.size() - 1) begin
            checkOutput("entry.busy", 32'(busy), 1);
            checkOutput("entry.rnd_get", 32'(rnd_get), 0);
            checkOutput("entry.fail", 32'(fail), 0);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      start = 1'b0;
      btn_valid = 1'b0;
      btn_value = 2'b00;
      lfsrReseed = 1'b1;
      repeat (3) stepCycle;
      checkAll("reset", 0, 0, 0, 0, 0, 0);
      checkOutput("reset.show_value", 32'(show_value), 0);
      reset = 1'b0;
      lfsrReseed = 1'b0;
      modelState = 3'b111;
      stepCycle;
      checkAll("idle", 0, 0, 0, 0, 0, 0);

      // Game 1: first round, then a wrong entry in round 2
      base = getCount;
      startGame;
      playback;
      checkOutput("g1.gets_r1", 32'(getCount - base), 1);
      enterSequence(-1, 2'd0);
      applyStimulus;
      playback;
      enterSequence(1, 2'd0);
      checkAll("g1.fail", 0, 0, 0, 2, 0, 1);
      for (int k = 0; k < 3; k++) begin
         stepCycle;
         checkOutput("g1.fail_hold", 32'(fail), 1);
      end
      checkOutput("g1.gets_total", 32'(getCount - base), 2);

      // Game 2: reseeded generator, full run to a win
      lfsrReseed = 1'b1;
      stepCycle;
      lfsrReseed = 1'b0;
      modelState = 3'b111;
      base = getCount;
      startGame;
      for (int r = 1; r <= MAX_LEN; r++) begin
         playback;
         if (r == 2) begin
            start = 1'b1;
            stepCycle;
            start = 1'b0;
            checkAll("g2.start_ignored", 0, 0, 1, 2, 0, 0);
         end
         if (r == MAX_LEN) begin
            checkOutput("g2.gets_total", 32'(getCount - base), MAX_LEN);
         end
         enterSequence(-1, 2'd0);
         if (r < MAX_LEN) applyStimulus;
      end
      checkAll("g2.win", 0, 0, 0, MAX_LEN, 1, 0);
      stepCycle;
      stepCycle;
      checkAll("g2.win_hold", 0, 0, 0, MAX_LEN, 1, 0);

      // Game 3: reset lands in the middle of round 3 playback
      base = getCount;
      startGame;
      for (int r = 1; r <= 2; r++) begin
         playback;
         enterSequence(-1, 2'd0);
         applyStimulus;
      end
      checkOutput("g3.show_r3", 32'(show_valid), 1);
      stepCycle;
      stepCycle;
      reset = 1'b1;
      #1;
      checkAll("g3.reset_now", 0, 0, 0, 0, 0, 0);
      checkOutput("g3.reset_value", 32'(show_value), 0);
      stepCycle;
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         stepCycle;
         checkAll("g3.after_reset", 0, 0, 0, 0, 0, 0);
      end
      checkOutput("g3.gets_total", 32'(getCount - base), 3);
      startGame;
      playback;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/random_sequence_controller.md
# random_sequence_controller

Sequencer for the game's pseudo-random pattern. It drives the 2-bit LFSR generator's `get` strobe and appends one random symbol per round to an internal sequence memory. It then plays the whole sequence to the display/LED stage and checks the player's button entries symbol by symbol. It sits between the LFSR generator, the button debouncers and the output display logic.

## Interface
- `MAX_LEN`, 16: maximum sequence length (rounds to win), 2..64.
- `SHOW_CYCLES`, 4: cycles each symbol is displayed, ≥1.
- `GAP_CYCLES`, 2: blank cycles after each displayed symbol, ≥1.
- `LW`, $clog2(MAX_LEN+1): width of `level`.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse; begins a new game.
- `rnd_get`  out  1  advance strobe to LFSR generator.
- `rnd_value`  in  2  LFSR generator's current random output.
- `btn_valid`  in  1  single-cycle pulse, player entered a symbol.
- `btn_value`  in  2  entered symbol, valid with `btn_valid`.
- `show_valid`  out  1  display a symbol this cycle.
- `show_value`  out  2  symbol to display, 0 when `show_valid`=0.
- `busy`  out  1  high in every state except IDLE, WIN, FAIL.
- `level`  out  LW  current sequence length.
- `win`  out  1  sticky, sequence of MAX_LEN completed.
- `fail`  out  1  sticky, wrong entry.

## Operation
- Reset (async): state IDLE, `level`=0, index=0, all outputs 0, sequence memory contents don't-care.
- States: IDLE, ADD, CAPT, SHOW_ON, SHOW_GAP, WAIT_IN, WIN, FAIL.
- IDLE/WIN/FAIL + `start`: clear `level`, `win`, `fail` → ADD. `start` ignored in all other states.
- ADD (1 cycle): `rnd_get`=1 → CAPT. The LFSR updates on this edge.
- CAPT (1 cycle): `mem[level]` ← `rnd_value`; `level` ← `level`+1; index ← 0 → SHOW_ON.
- SHOW_ON: `show_valid`=1, `show_value`=`mem[index]` for exactly SHOW_CYCLES cycles → SHOW_GAP.
- SHOW_GAP: outputs 0 for GAP_CYCLES cycles; then if index=`level`-1 → WAIT_IN with index ← 0, else index+1 → SHOW_ON.
- WAIT_IN: waits indefinitely. On `btn_valid`:
  - `btn_value`≠`mem[index]` → FAIL.
  - Match, index<`level`-1 → index+1, stay.
  - Match, index=`level`-1, `level`=MAX_LEN → WIN.
  - Match, index=`level`-1, `level`<MAX_LEN → ADD.
- WIN: `win`=1 until next `start` or reset.
- FAIL: `fail`=1 until next `start` or reset. `level` holds the failed round's length.
- `btn_valid` outside WAIT_IN: ignored, no effect.
- `rnd_get` is high only in ADD; exactly one pulse per round.
- `level` never exceeds MAX_LEN; index never exceeds `level`-1.

## Timing
- All outputs registered or decoded from the state register. No combinational path from `btn_*` or `rnd_value` to outputs.
- `start` sampled at edge t: ADD during cycle t+1, CAPT t+2, first SHOW_ON cycle t+3.
- Round N display duration: N·(SHOW_CYCLES+GAP_CYCLES) cycles.
- Final matching `btn_valid` at edge e: ADD (or WIN/FAIL) visible from cycle e+1.
- Reset asserted mid-game: immediate return to IDLE with all outputs 0. No `rnd_get` is issued during or after reset until `start`.
- `start` and `btn_valid` coincident in WAIT_IN: `start` ignored, `btn_valid` processed.

## Test plan
- Reset, then `start` with a behavioral LFSR (seed 111, taps [2]^[0]) attached → `rnd_get` one cycle at t+1; `mem[0]`=3; `level`=1; `show_valid` high 4 cycles with value 3, then 2 low; `busy`=1.
- Correct entries over 4 rounds → captured symbols 3,1,2,1. Round-4 playback shows exactly 3,1,2,1; `level`=4; exactly 4 `rnd_get` pulses total.
- Round 2, wrong entry 0 where 1 expected → FAIL next cycle; `fail`=1; `level`=2; no further `rnd_get`; `start` clears `fail` and restarts at `level`=1.
- MAX_LEN=2, all entries correct → `win`=1 after the second round's last entry; `busy`=0; `level`=2.
- `btn_valid` pulses during SHOW_ON/SHOW_GAP and `start` during WAIT_IN → no state, index or `level` change.
- `reset` asserted during SHOW_ON of round 3 → same cycle, all outputs 0, `level`=0; stays IDLE until `start`.
